// File: rtl/adder_chunked_seq_if.sv
// ---------------------------------------------------------------------------
// adder_chunked_seq_if
//   Request/response bundle for the chunked multi-cycle adder/subtractor.
//   master : requester (drives start/a/b/cin/sub, observes results)
//   slave  : adder     (observes the request, drives busy/done/sum/cout/ovf)
//   start  - request, taken only when the adder is idle or finishing
//   a, b   - operands, sampled with start
//   cin    - carry-in for addition (ignored when subtracting)
//   sub    - 0: a+b+cin, 1: a-b
//   busy   - operation in progress
//   done   - one-cycle pulse when results become valid
//   sum    - WIDTH-bit result
//   cout   - carry out of the MSB (subtraction: 1 = no borrow)
//   ovf    - two's-complement signed overflow
// ---------------------------------------------------------------------------
interface adder_chunked_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/adder_chunked_seq.sv
// ---------------------------------------------------------------------------
// adder_chunked_seq
//   Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per
//   clock, rippling the carry through a register between chunks. One
//   operation takes WIDTH/CHUNK cycles in RUN plus one DONE cycle.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - adder_chunked_seq_if slave port (start/a/b/cin/sub in,
//           busy/done/sum/cout/ovf out)
// ---------------------------------------------------------------------------
module adder_chunked_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_chunked_seq_if.slave  bus
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q, cout_q, ovf_q;

  logic              load, step, last;
  logic [BW-1:0]     base;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    add_res;
  logic              ovf_c;

  // Chunk datapath: one CHUNK-bit slice plus the registered carry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    base    = BW'(idx_q) * BW'(CHUNK);
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    add_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last    = (idx_q == IDXW'(NCH - 1));
    // Carry into the MSB is recovered from the MSB sum bit (s = a ^ b ^ c),
    // which works for any CHUNK including 1.
    ovf_c   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ add_res[CHUNK-1] ^ add_res[CHUNK];
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too; they are small and a
      // known value keeps post-reset behaviour deterministic.
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_q     <= bus.a;
      // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.cin;
      idx_q   <= '0;
      sum_q   <= '0;
    end else if (step) begin
      sum_q[base +: CHUNK] <= add_res[CHUNK-1:0];
      carry_q              <= add_res[CHUNK];
      if (last) begin
        cout_q <= add_res[CHUNK];
        ovf_q  <= ovf_c;
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_adder_chunked_seq.sv
// ---------------------------------------------------------------------------
// tb_adder_chunked_seq
//   Bench for adder_chunked_seq. A 16/4 instance runs directed operations
//   whose expected results come from an integer-arithmetic model; a compare
//   process checks busy/done every cycle, results on the done pulse and the
//   held results while idle. Three 4-bit instances (CHUNK 1, 2, 4) run an
//   exhaustive sweep against the same model, including done latency.
// ---------------------------------------------------------------------------
module tb_adder_chunked_seq;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_chunked_seq_if #(.WIDTH(W)) m ();
  adder_chunked_seq_if #(.WIDTH(4)) s1 ();
  adder_chunked_seq_if #(.WIDTH(4)) s2 ();
  adder_chunked_seq_if #(.WIDTH(4)) s4 ();

  adder_chunked_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  adder_chunked_seq #(.WIDTH(4), .CHUNK(1)) dut_c1 (.clk(clk), .rst_n(rst_n), .bus(s1));
  adder_chunked_seq #(.WIDTH(4), .CHUNK(2)) dut_c2 (.clk(clk), .rst_n(rst_n), .bus(s2));
  adder_chunked_seq #(.WIDTH(4), .CHUNK(4)) dut_c4 (.clk(clk), .rst_n(rst_n), .bus(s4));

  // Shared stimulus for the three sweep instances.
  logic       sw_start = 1'b0;
  logic [3:0] sw_a = '0, sw_b = '0;
  logic       sw_cin = 1'b0, sw_sub = 1'b0;

  assign s1.start = sw_start; assign s1.a = sw_a; assign s1.b = sw_b;
  assign s1.cin   = sw_cin;   assign s1.sub = sw_sub;
  assign s2.start = sw_start; assign s2.a = sw_a; assign s2.b = sw_b;
  assign s2.cin   = sw_cin;   assign s2.sub = sw_sub;
  assign s4.start = sw_start; assign s4.a = sw_a; assign s4.b = sw_b;
  assign s4.cin   = sw_cin;   assign s4.sub = sw_sub;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Arithmetic model: plain integer add/subtract, signed range test for ovf.
  function automatic void model(input int w, input int a, input int b, input int cin,
                                input int sub, output int s, output int c, output int o);
    int md, sa, sb, u, r;
    md = 1 << w;
    sa = (a >= md / 2) ? a - md : a;
    sb = (b >= md / 2) ? b - md : b;
    if (sub != 0) begin
      u = a - b;
      c = (a >= b) ? 1 : 0;
      r = sa - sb;
    end else begin
      u = a + b + cin;
      c = (u >= md) ? 1 : 0;
      r = sa + sb + cin;
    end
    s = ((u % md) + md) % md;
    o = (r < -(md / 2) || r > (md / 2) - 1) ? 1 : 0;
  endfunction

  // Expectation ring: the driver owns wr_ptr and the entries, the compare
  // process owns rd_ptr.
  typedef struct {
    int         st;
    int         due;
    logic [W-1:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t eq [64];
  int   wr_ptr = 0;
  int   rd_ptr = 0;

  logic [W-1:0] hold_s;
  logic         hold_c, hold_o;
  logic         exp_done, exp_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset outputs", {m.busy, m.done, m.cout, m.ovf, m.sum}, '0);
      rd_ptr = wr_ptr;
      hold_s = '0;
      hold_c = 1'b0;
      hold_o = 1'b0;
    end else begin
      exp_done = (rd_ptr != wr_ptr) && (eq[rd_ptr].due == cyc);
      exp_busy = (rd_ptr != wr_ptr) && (cyc >= eq[rd_ptr].st) && (cyc < eq[rd_ptr].due);
      check("done", m.done, exp_done);
      check("busy", m.busy, exp_busy);
      if (exp_done) begin
        check("result sum",  m.sum,  eq[rd_ptr].s);
        check("result cout", m.cout, eq[rd_ptr].c);
        check("result ovf",  m.ovf,  eq[rd_ptr].o);
        hold_s = eq[rd_ptr].s;
        hold_c = eq[rd_ptr].c;
        hold_o = eq[rd_ptr].o;
        rd_ptr = (rd_ptr + 1) % 64;
      end else if (!exp_busy) begin
        check("held sum",  m.sum,  hold_s);
        check("held cout", m.cout, hold_c);
        check("held ovf",  m.ovf,  hold_o);
      end
    end
  end

  // Called #1 after a rising edge; start is sampled on the next edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, output int due);
    int s, c, o;
    model(W, int'(a), int'(b), int'(cin), int'(sub), s, c, o);
    m.a = a; m.b = b; m.cin = cin; m.sub = sub; m.start = 1'b1;
    eq[wr_ptr].st  = cyc + 1;
    eq[wr_ptr].due = cyc + 1 + NCH;
    eq[wr_ptr].s   = W'(s);
    eq[wr_ptr].c   = c[0];
    eq[wr_ptr].o   = o[0];
    due = cyc + 1 + NCH;
    wr_ptr = (wr_ptr + 1) % 64;
    @(posedge clk); #1;
    m.start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rd_ptr != wr_ptr && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain within budget", (rd_ptr == wr_ptr), 1'b1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic pin(input string name, input int a, input int b, input int cin, input int sub,
                     input int es, input int ec, input int eo);
    int s, c, o;
    model(W, a, b, cin, sub, s, c, o);
    check({name, " sum"},  s, es);
    check({name, " cout"}, c, ec);
    check({name, " ovf"},  o, eo);
  endtask

  initial begin
    int due;
    int lat [3];
    logic [5:0] res [3];
    int s, c, o;

    rst_n = 1'b0;
    m.start = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;

    // Hand-computed results pin the model.
    pin("model 00FF+0001",   16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    pin("model FFFF+0001",   16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    pin("model 7FFF+0+1",    16'h7FFF, 16'h0000, 1, 0, 16'h8000, 0, 1);
    pin("model 0005-0007",   16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    pin("model 8000-0001",   16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, due); wait_drain();
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, due); wait_drain();
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, due); wait_drain();
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, due); wait_drain();
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, due); wait_drain();
    // cin must be ignored when subtracting.
    do_op(16'h1234, 16'h0234, 1'b1, 1'b1, due); wait_drain();

    // start pulsed two cycles into RUN with different operands: ignored.
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, due);
    @(posedge clk); #1;
    m.a = 16'hFFFF; m.b = 16'hFFFF; m.cin = 1'b1; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    wait_drain();

    // start held in DONE: second operation runs back to back.
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, due);
    while (cyc != due) begin @(posedge clk); #1; end
    do_op(16'h4000, 16'hC001, 1'b0, 1'b1, due);
    wait_drain();

    // Reset for one cycle mid-RUN: aborted, no done pulse.
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, due);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    do_op(16'h7FFE, 16'h0001, 1'b1, 1'b0, due); wait_drain();

    // Exhaustive 4-bit sweep over CHUNK = 1, 2, 4.
    for (int sb = 0; sb < 2; sb++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            @(posedge clk); #1;
            sw_a = 4'(x); sw_b = 4'(y); sw_cin = ci[0]; sw_sub = sb[0];
            sw_start = 1'b1;
            @(posedge clk); #1;
            sw_start = 1'b0;
            for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = '0; end
            for (int k = 0; k <= 6; k++) begin
              @(negedge clk);
              if (s1.done && lat[0] < 0) begin lat[0] = k; res[0] = {s1.cout, s1.ovf, s1.sum}; end
              if (s2.done && lat[1] < 0) begin lat[1] = k; res[1] = {s2.cout, s2.ovf, s2.sum}; end
              if (s4.done && lat[2] < 0) begin lat[2] = k; res[2] = {s4.cout, s4.ovf, s4.sum}; end
            end
            model(4, x, y, ci, sb, s, c, o);
            check($sformatf("sweep c1 a=%0d b=%0d cin=%0d sub=%0d res", x, y, ci, sb), res[0], {c[0], o[0], s[3:0]});
            check($sformatf("sweep c2 a=%0d b=%0d cin=%0d sub=%0d res", x, y, ci, sb), res[1], {c[0], o[0], s[3:0]});
            check($sformatf("sweep c4 a=%0d b=%0d cin=%0d sub=%0d res", x, y, ci, sb), res[2], {c[0], o[0], s[3:0]});
            check($sformatf("sweep c1 a=%0d b=%0d latency", x, y), lat[0], 4);
            check($sformatf("sweep c2 a=%0d b=%0d latency", x, y), lat[1], 2);
            check($sformatf("sweep c4 a=%0d b=%0d latency", x, y), lat[2], 1);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_chunked_seq.md
Name: adder_chunked_seq

Overview:
Parametrised multi-cycle adder/subtractor and the sequential successor of the single-bit half adder. It adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks. It uses a start/busy/done handshake. It serves datapaths where a full-width single-cycle carry chain does not meet timing or area.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per clock; CHUNK == WIDTH gives single-cycle operation.
NCH (localparam), WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
cin    input   1      carry-in for add; ignored when sub=1
sub    input   1      0 = a+b+cin, 1 = a-b; sampled with start
busy   output  1      operation in progress
done   output  1      one-cycle pulse when results become valid
sum    output  WIDTH  result
cout   output  1      carry out of the MSB (for sub: 1 = no borrow)
ovf    output  1      two's-complement signed overflow

Behaviour:
- Reset (async assert, sync deassert by the caller): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal chunk index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a and either b (sub=0) or ~b (sub=1), and set carry reg = (sub ? 1 : cin). Set chunk index=0, clear sum, go to RUN, busy=1.
- RUN: each cycle compute {c, s} = a_chunk[k] + b_chunk[k] + carry, with CHUNK+1 bits of width.
  - Write s into sum[k*CHUNK +: CHUNK] and store c into the carry reg.
  - On k == NCH-1: capture cout=c, and capture ovf = carry into MSB XOR c, computed within the final chunk. Go to DONE.
  - Otherwise k=k+1.
- DONE: done=1 and busy=0 for exactly one cycle.
  - With start=1 in DONE, latch new operands and go to RUN; back-to-back throughput is one op per NCH+1 cycles.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E, done high after edge E+NCH, and sum/cout/ovf are valid from that point.
- Result hold: sum/cout/ovf hold their values in IDLE until the next accepted start. During RUN, sum is partially updated and is not guaranteed valid.
- start while in RUN is ignored. Operand changes after the start edge have no effect.
- Reset mid-operation: the op is aborted, all outputs return to reset values, and no done pulse is produced.
- CHUNK == WIDTH: RUN lasts one cycle, so done follows start by 1 cycle.
- Subtraction semantics: a + ~b + 1. cout=0 means a < b (unsigned). ovf is valid for signed interpretation.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x00FF + 0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0; done exactly 4 cycles after start edge; busy high for those 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- start pulsed again 2 cycles into RUN with different operands -> ignored; first result unchanged. start held during DONE -> second op accepted and completes 4 cycles later.
- rst_n low for 1 cycle mid-RUN -> outputs all 0 immediately, FSM IDLE, no done pulse; a fresh op afterwards completes correctly.
- Exhaustive sweep at WIDTH=4 with CHUNK in {1,2,4}, all a, b, cin, sub -> sum/cout/ovf match the behavioural model a+b+cin / a-b every op; done latency = WIDTH/CHUNK.
